// File: rtl/mul_accum.sv
// Sums COUNT unsigned 16-bit products into an ACC_W accumulator; MUL_ACCUM_SAT_EN selects saturation instead of wrap.
// Latency: sum/out_valid registered on the edge accepting the COUNT-th product; one result per COUNT+1 cycles at best.
// Backpressure: in_ready drops while a result is held; sum/ovf/out_valid hold until out_ready.
module mul_accum #(
    parameter int ACC_W = 24,
    parameter int COUNT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      mul,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [ACC_W-1:0] sum,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             ovf,
    output logic [7:0]       cnt
);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_upd;
    logic [ACC_W:0]   add_full;
    logic             sticky;
    logic             sticky_upd;
    logic             accept;
    logic             last;

    assign accept     = in_valid & in_ready;
    assign last       = (cnt == 8'(COUNT - 1));
    assign add_full   = {1'b0, acc} + {{(ACC_W - 15){1'b0}}, mul};
    assign sticky_upd = sticky | add_full[ACC_W];

`ifdef MUL_ACCUM_SAT_EN
    // once the group has overflowed, the accumulator is pinned at all-ones
    assign acc_upd = sticky_upd ? {ACC_W{1'b1}} : add_full[ACC_W-1:0];
`else
    assign acc_upd = add_full[ACC_W-1:0];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ACCUM;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            ACCUM: begin
                in_ready = 1'b1;
                if (in_valid && last) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = ACCUM;
                end
            end
            default: state_nxt = ACCUM;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc    <= '0;
            cnt    <= '0;
            sticky <= 1'b0;
            sum    <= '0;
            ovf    <= 1'b0;
        end else if (accept) begin
            if (last) begin
                sum    <= acc_upd;
                ovf    <= sticky_upd;
                acc    <= '0;
                cnt    <= '0;
                sticky <= 1'b0;
            end else begin
                acc    <= acc_upd;
                cnt    <= cnt + 8'd1;
                sticky <= sticky_upd;
            end
        end
    end

endmodule
